// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand-entry block.
//   - keypad code constants for the operator, equals and clear keys
//   - entry state encoding (also exported on the debug state port)
//   - key classification type and helper used by the entry FSM
package calc_pkg;

    localparam int DIGITS_DEFAULT = 4;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_EQ    = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] OP1    = 3'd1;
    localparam logic [2:0] OP2    = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    typedef enum logic [2:0] {
        KC_DIGIT,
        KC_ADDSUB,
        KC_EQ,
        KC_CLR,
        KC_NONE
    } key_class_e;

    // Codes 14 and 15 are reserved and fall into KC_NONE so they are ignored.
    function automatic key_class_e classify_key(input logic [3:0] code);
        key_class_e cls;
        if (code <= 4'd9) begin
            cls = KC_DIGIT;
        end else if ((code == KEY_PLUS) || (code == KEY_MINUS)) begin
            cls = KC_ADDSUB;
        end else if (code == KEY_EQ) begin
            cls = KC_EQ;
        end else if (code == KEY_CLR) begin
            cls = KC_CLR;
        end else begin
            cls = KC_NONE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Keypad edge detector.
// Registers the key_valid level and produces a one-cycle key_stb in the
// cycle after key_valid rises, together with the key_code captured in the
// edge-detect cycle. Holding a key therefore yields exactly one strobe.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   key_valid     : level from the keypad scanner
//   key_code      : code presented by the scanner
//   key_stb       : one-cycle pulse, one per key press
//   key_sampled   : key_code captured on the rising edge of key_valid
module key_edge_det (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_stb,
    output logic [3:0] key_sampled
);

    logic       key_valid_d_q, key_valid_d_d;
    logic       stb_q, stb_d;
    logic [3:0] code_q, code_d;

    always_comb begin
        key_valid_d_d = key_valid;
        stb_d         = key_valid & ~key_valid_d_q;
        code_d        = stb_d ? key_code : code_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_valid_d_q <= 1'b0;
            stb_q         <= 1'b0;
            code_q        <= 4'd0;
        end else begin
            key_valid_d_q <= key_valid_d_d;
            stb_q         <= stb_d;
            code_q        <= code_d;
        end
    end

    assign key_stb     = stb_q;
    assign key_sampled = code_q;

endmodule

// File: rtl/calc_key_entry.sv
// Calculator operand-entry stage.
// Turns keypad presses into two packed-BCD operands (reg1, reg2) and an
// add/subtract select (regop) for the ALU, and selects what the display
// shows. After '=' the block waits one cycle for the ALU's registered
// result, then raises res_ready until the next digit starts a new entry.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   key_valid   : keypad level, a key acts once per rising edge
//   key_code    : 0-9 digits, 10 '+', 11 '-', 12 '=', 13 clear
//   reg1, reg2  : operands, packed BCD, most significant digit on top
//   regop       : 1 = add, 0 = subtract
//   disp        : operand currently shown
//   entry_full  : operand being edited already holds DIGITS digits
//   res_ready   : ALU result valid for display
//   state       : entry state, for debug
module calc_key_entry
    import calc_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic [4*DIGITS-1:0] reg1,
    output logic [4*DIGITS-1:0] reg2,
    output logic                regop,
    output logic [4*DIGITS-1:0] disp,
    output logic                entry_full,
    output logic                res_ready,
    output logic [2:0]          state
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

    logic       key_stb;
    logic [3:0] key_d;
    key_class_e kcls;

    key_edge_det u_edge (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_stb     (key_stb),
        .key_sampled (key_d)
    );

    assign kcls = classify_key(key_d);

    logic [W-1:0]  reg1_q, reg1_d;
    logic [W-1:0]  reg2_q, reg2_d;
    logic          regop_q, regop_d;
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic [CW-1:0] cnt2_q, cnt2_d;
    logic [2:0]    state_q, state_d;

    // A digit may be appended unless it is a leading zero or the operand
    // is already full.
    logic app1_ok, app2_ok;
    assign app1_ok = !((reg1_q == '0) && (key_d == 4'd0)) && (cnt1_q != CNT_FULL);
    assign app2_ok = !((reg2_q == '0) && (key_d == 4'd0)) && (cnt2_q != CNT_FULL);

    logic is_digit, is_addsub, is_eq, is_clr;
    assign is_digit  = key_stb && (kcls == KC_DIGIT);
    assign is_addsub = key_stb && (kcls == KC_ADDSUB);
    assign is_eq     = key_stb && (kcls == KC_EQ);
    assign is_clr    = key_stb && (kcls == KC_CLR);

    always_comb begin
        reg1_d  = reg1_q;
        reg2_d  = reg2_q;
        regop_d = regop_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        state_d = state_q;

        if (is_clr) begin
            reg1_d  = '0;
            reg2_d  = '0;
            regop_d = 1'b1;
            cnt1_d  = '0;
            cnt2_d  = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_digit) begin
                        if (app1_ok) begin
                            reg1_d = {reg1_q[W-5:0], key_d};
                            cnt1_d = cnt1_q + CW'(1);
                        end
                        state_d = OP1;
                    end else if (is_addsub) begin
                        // Operator first: operand 1 is taken as zero.
                        regop_d = (key_d == KEY_PLUS);
                        reg1_d  = '0;
                        cnt1_d  = '0;
                        reg2_d  = '0;
                        cnt2_d  = '0;
                        state_d = OP2;
                    end
                end
                OP1: begin
                    if (is_digit) begin
                        if (app1_ok) begin
                            reg1_d = {reg1_q[W-5:0], key_d};
                            cnt1_d = cnt1_q + CW'(1);
                        end
                    end else if (is_addsub) begin
                        regop_d = (key_d == KEY_PLUS);
                        reg2_d  = '0;
                        cnt2_d  = '0;
                        state_d = OP2;
                    end
                end
                OP2: begin
                    if (is_digit) begin
                        if (app2_ok) begin
                            reg2_d = {reg2_q[W-5:0], key_d};
                            cnt2_d = cnt2_q + CW'(1);
                        end
                    end else if (is_addsub) begin
                        // Operator may be corrected only before operand 2
                        // has any digits; there is no operation chaining.
                        if (cnt2_q == '0) begin
                            regop_d = (key_d == KEY_PLUS);
                        end
                    end else if (is_eq) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    // One cycle for the ALU's registered output to settle.
                    state_d = RESULT;
                end
                RESULT: begin
                    if (is_digit) begin
                        reg1_d  = {{(W-4){1'b0}}, key_d};
                        cnt1_d  = (key_d != 4'd0) ? CW'(1) : '0;
                        reg2_d  = '0;
                        cnt2_d  = '0;
                        state_d = OP1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg1_q  <= '0;
            reg2_q  <= '0;
            regop_q <= 1'b1;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            state_q <= IDLE;
        end else begin
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            regop_q <= regop_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            state_q <= state_d;
        end
    end

    // Display shows operand 1 until operand 2 has a digit; after '=' it
    // shows operand 2's slot, which downstream swaps for the ALU result.
    always_comb begin
        disp       = reg2_q;
        entry_full = 1'b0;
        case (state_q)
            IDLE, OP1: begin
                disp       = reg1_q;
                entry_full = (cnt1_q == CNT_FULL);
            end
            OP2: begin
                disp       = (cnt2_q == '0) ? reg1_q : reg2_q;
                entry_full = (cnt2_q == CNT_FULL);
            end
            default: begin
                disp       = reg2_q;
                entry_full = 1'b0;
            end
        endcase
    end

    assign reg1      = reg1_q;
    assign reg2      = reg2_q;
    assign regop     = regop_q;
    assign res_ready = (state_q == RESULT);
    assign state     = state_q;

endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
Upstream operand-entry stage of the calculator datapath. It turns a stream of keypad codes into the two 4-digit packed-BCD operands and the add/subtract select consumed by the ALU, under control of a small entry state machine. It also drives the display value and a result-ready flag that downstream display logic uses to switch from showing operands to showing the ALU result.

Parameters:
DIGITS, 4, number of BCD digits per operand; operand width is 4*DIGITS; the ALU requires 4.

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
key_valid  input  1  level from keypad scanner; high while a key is held
key_code  input  4  0-9 digit, 10 '+', 11 '-', 12 '=', 13 'C' (clear); 14-15 reserved
reg1  output  4*DIGITS  operand 1, packed BCD, most significant digit in the top nibble
reg2  output  4*DIGITS  operand 2, packed BCD
regop  output  1  1 = add, 0 = subtract
disp  output  4*DIGITS  operand currently being shown
entry_full  output  1  the operand being edited already holds DIGITS significant digits
res_ready  output  1  ALU result is valid for display
state  output  3  current state encoding, for debug

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
- Key acceptance: a key is accepted only on the rising edge of key_valid, i.e. key_valid=1 while the registered key_valid_d=0. key_code is sampled in that same cycle. Holding a key produces exactly one action. Reserved codes are ignored.
- Action timing: each accepted key acts in the cycle after the edge, so outputs update 1 clk after the edge-detect cycle.
- Reset values: reg1=0, reg2=0, regop=1, disp=0, entry_full=0, res_ready=0, state=IDLE, key_valid_d=0, both digit counts 0. Reset mid-entry discards everything.
- Digit entry: new = {cur[4*DIGITS-5:0], d}, and the digit count increments.
  - If cur==0 and d==0, nothing changes (leading zeros are not counted).
  - If count==DIGITS, the digit is ignored.
  - entry_full = (count of the edited operand == DIGITS).
- States:
  - IDLE: digit -> reg1 = d (a 0 leaves it unchanged), go to OP1. '+'/'-' -> set regop, go to OP2 with reg1=0. '=' is ignored.
  - OP1: digit -> append to reg1. '+' -> regop=1; '-' -> regop=0; either clears reg2 and its count, go to OP2. '=' is ignored.
  - OP2: digit -> append to reg2. '+'/'-' with reg2 count 0 -> replace regop, stay in OP2. '+'/'-' with count > 0 -> ignored (no chaining). '=' -> go to WAIT.
  - WAIT: exactly one cycle, to cover the ALU's registered latency, then go to RESULT. Keys accepted in WAIT are dropped.
  - RESULT: res_ready=1. reg1, reg2 and regop are held. Digit -> reg1 = d, reg2 = 0, both counts reset, res_ready=0, go to OP1. '+', '-' and '=' are ignored.
- Clear: 'C' in any state returns the block to reset values in one cycle, except key_valid_d, which keeps tracking.
- Display select: disp = reg1 in IDLE/OP1; in OP2 disp = reg2, or reg1 while reg2 count==0; in WAIT/RESULT disp = reg2.
- Operand stability: reg1, reg2 and regop change only on accepted keys, so the ALU sees stable operands from OP2 onward.
- Reset priority: reset overrides any key arriving in the same cycle.

Decomposition:
- Shared package calc_pkg:
  - key code constants: KEY_PLUS=10, KEY_MINUS=11, KEY_EQ=12, KEY_CLR=13
  - state encoding: IDLE=0, OP1=1, OP2=2, WAIT=3, RESULT=4
  - DIGITS default
- One sub-module, key_edge_det: registers key_valid and outputs a one-cycle key_stb plus the sampled key_code.

Test Plan:
- reset; press 1,2,3 then '+', 4,5, '=' -> reg1=16'h0123, reg2=16'h0045, regop=1; res_ready=1 two cycles after the '=' action.
- press 0,0,7 -> reg1=16'h0007 with digit count 1; then press 1,2,3,4 -> reg1=16'h7123, entry_full=1, and the fifth digit 4 is ignored.
- 9, '-', '+' (reg2 still empty) -> regop=1; then 5, '-' -> regop stays 1 and reg2=16'h0005.
- hold key_valid high for 10 cycles with code 3 -> exactly one digit is entered (reg1=16'h0003).
- in RESULT press 8 -> reg1=16'h0008, reg2=0, res_ready=0, state=OP1; then 'C' -> all outputs are back to reset values.
- assert reset in OP2 in the same cycle as a digit edge -> the reset values win and the digit is not applied.
